// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-ported dmem.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface dmem_arbiter_if #(
   parameter int ADDR_WIDTH = 22,
   parameter int DATA_WIDTH = 32
);
   logic                  req0Valid;
   logic                  req0Write;
   logic [ADDR_WIDTH-1:0] req0Address;
   logic [DATA_WIDTH-1:0] req0DataIn;
   logic                  req0Ready;
   logic                  resp0Valid;
   logic [DATA_WIDTH-1:0] resp0Data;

   logic                  req1Valid;
   logic                  req1Write;
   logic [ADDR_WIDTH-1:0] req1Address;
   logic [DATA_WIDTH-1:0] req1DataIn;
   logic                  req1Ready;
   logic                  resp1Valid;
   logic [DATA_WIDTH-1:0] resp1Data;

   logic [ADDR_WIDTH-1:0] memAddress;
   logic [DATA_WIDTH-1:0] memDataIn;
   logic                  memWriteEnable;
   logic [DATA_WIDTH-1:0] memDataOut;
   logic                  busy;

   modport slave (
      input  req0Valid, req0Write, req0Address, req0DataIn,
      output req0Ready, resp0Valid, resp0Data,
      input  req1Valid, req1Write, req1Address, req1DataIn,
      output req1Ready, resp1Valid, resp1Data,
      output memAddress, memDataIn, memWriteEnable, busy,
      input  memDataOut
   );

   modport master (
      output req0Valid, req0Write, req0Address, req0DataIn,
      input  req0Ready, resp0Valid, resp0Data,
      output req1Valid, req1Write, req1Address, req1DataIn,
      input  req1Ready, resp1Valid, resp1Data,
      input  memAddress, memDataIn, memWriteEnable, busy,
      output memDataOut
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester arbiter for the single-ported data memory.
// Each transaction runs IDLE (accept) -> ACCESS (memory cycle) -> RESP (one-cycle response pulse).
module dmem_arbiter #(
   parameter int ADDR_WIDTH = 22,
   parameter int DATA_WIDTH = 32
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                state_q, state_d;
   logic                  prio_q, prio_d;
   logic                  gnt_q, gnt_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  resp0_valid_q, resp0_valid_d;
   logic                  resp1_valid_q, resp1_valid_d;

   logic win0, win1, rdy0, rdy1;

   // Sole requester always wins; on contention the priority pointer decides.
   assign win0 = bus.req0Valid && (!bus.req1Valid || !prio_q);
   assign win1 = bus.req1Valid && (!bus.req0Valid ||  prio_q);
   assign rdy0 = (state_q == IDLE) && win0;
   assign rdy1 = (state_q == IDLE) && win1;

   always_comb begin
      state_d       = state_q;
      prio_d        = prio_q;
      gnt_d         = gnt_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      resp0_valid_d = 1'b0;
      resp1_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (rdy0 || rdy1) begin
               gnt_d   = rdy1;
               prio_d  = ~rdy1;
               we_d    = rdy1 ? bus.req1Write   : bus.req0Write;
               addr_d  = rdy1 ? bus.req1Address : bus.req0Address;
               wdata_d = rdy1 ? bus.req1DataIn  : bus.req0DataIn;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            // we_q doubles as the latched write bit while in ACCESS
            if (!we_q) begin
               rdata_d = bus.memDataOut;
            end
            we_d          = 1'b0;
            resp0_valid_d = !gnt_q;
            resp1_valid_d =  gnt_q;
            state_d       = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         prio_q        <= 1'b0;
         gnt_q         <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         rdata_q       <= '0;
         resp0_valid_q <= 1'b0;
         resp1_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         prio_q        <= prio_d;
         gnt_q         <= gnt_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rdata_q       <= rdata_d;
         resp0_valid_q <= resp0_valid_d;
         resp1_valid_q <= resp1_valid_d;
      end
   end

   assign bus.req0Ready      = rdy0;
   assign bus.req1Ready      = rdy1;
   assign bus.resp0Valid     = resp0_valid_q;
   assign bus.resp1Valid     = resp1_valid_q;
   assign bus.resp0Data      = rdata_q;
   assign bus.resp1Data      = rdata_q;
   assign bus.memAddress     = addr_q;
   assign bus.memDataIn      = wdata_q;
   assign bus.memWriteEnable = we_q;
   assign bus.busy           = (state_q != IDLE);

endmodule
